sdram_device_emu: RTL and testbench

//  Synthesizable SDR SDRAM device emulator: the chip-side responder to the sopc SDRAM controller pins.

---
 rtl/sdram_emu_pkg.sv | 41 ++++
 rtl/sdram_emu_mem.sv | 25 ++
 rtl/sdram_device_emu.sv | 174 +++++++++++++++++
 tb/tb_sdram_device_emu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_emu_pkg.sv
// Shared definitions for the SDR SDRAM device emulator: command encodings,
// first-error codes and mode-register field positions.
package sdram_emu_pkg;

  localparam int DATA_W = 16;

  // {ras_n, cas_n, we_n} with cs_n low
  localparam logic [2:0] CMD_LOAD_MODE  = 3'b000;
  localparam logic [2:0] CMD_REFRESH    = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE  = 3'b010;
  localparam logic [2:0] CMD_ACTIVE     = 3'b011;
  localparam logic [2:0] CMD_WRITE      = 3'b100;
  localparam logic [2:0] CMD_READ       = 3'b101;
  localparam logic [2:0] CMD_BURST_TERM = 3'b110;
  localparam logic [2:0] CMD_NOP        = 3'b111;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_NOT_INIT  = 3'd1,
    ERR_CLOSED    = 3'd2,
    ERR_TRCD      = 3'd3,
    ERR_ACT_OPEN  = 3'd4,
    ERR_REF_OPEN  = 3'd5,
    ERR_MODE_OPEN = 3'd6,
    ERR_MODE_BAD  = 3'd7
  } err_code_e;

  localparam int A10_BIT     = 10;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_BL_LSB = 0;

  // Only CAS latency 2/3 with burst length 1 is supported.
  function automatic logic mode_valid(input logic [11:0] mode);
    logic [2:0] cl;
    logic [2:0] bl;
    cl = mode[MODE_CL_LSB +: 3];
    bl = mode[MODE_BL_LSB +: 3];
    return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
  endfunction

endpackage

// File: rtl/sdram_emu_mem.sv
// Single-port word RAM with two byte enables and a registered read port.
module sdram_emu_mem
  import sdram_emu_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              rd,
  input  logic [1:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**AW];

  // Byte-lane writes and registered reads; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we && be[0]) mem_r[addr][7:0] <= wdata[7:0];
    if (we && be[1]) mem_r[addr][15:8] <= wdata[15:8];
    if (rd) rdata <= mem_r[addr];
  end

endmodule

// File: rtl/sdram_device_emu.sv
// SDR SDRAM chip-side responder: command decode, per-bank row tracking,
// CAS-latency read pipeline with DQM, and a first-error latch.
module sdram_device_emu
  import sdram_emu_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int COL_W   = 8,
  parameter int TRCD    = 3,
  parameter int REF_MIN = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [11:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic [1:0]  sdram_dq_oe,
  output logic        init_done,
  output logic        err_sticky,
  output logic [2:0]  err_code
);

  localparam logic [3:0] TRCD_LOAD  = 4'(TRCD - 1);
  localparam logic [3:0] REF_TARGET = 4'(REF_MIN);
  localparam int         FULL_W     = 2 + 12 + COL_W;

  logic [11:0] open_row_r [4];
  logic [3:0]  trcd_r [4];
  logic [3:0]  open_r;
  logic [2:0]  cl_r;
  logic [3:0]  ref_cnt_r;
  logic        pv0_r, pv1_r;
  logic [15:0] pd1_r;
  logic [1:0]  dqm_d_r;
  err_code_e   err_r;

  logic [2:0]        cmd_s;
  logic              live_s, is_act_s, is_rd_s, is_wr_s, is_pre_s, is_ref_s, is_mode_s, is_bt_s;
  logic              bank_open_s, any_open_s, mem_we_s, mem_rd_s, flush_s, out_v_s;
  logic [FULL_W-1:0] full_addr_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic [15:0]       mem_rdata_s, out_d_s;
  err_code_e         new_err_s;

  assign cmd_s     = sdram_cs_n ? CMD_NOP : {sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign live_s    = sdram_cke && !reset_reset;
  assign is_act_s  = live_s && (cmd_s == CMD_ACTIVE);
  assign is_rd_s   = live_s && (cmd_s == CMD_READ);
  assign is_wr_s   = live_s && (cmd_s == CMD_WRITE);
  assign is_pre_s  = live_s && (cmd_s == CMD_PRECHARGE);
  assign is_ref_s  = live_s && (cmd_s == CMD_REFRESH);
  assign is_mode_s = live_s && (cmd_s == CMD_LOAD_MODE);
  assign is_bt_s   = live_s && (cmd_s == CMD_BURST_TERM);

  assign bank_open_s = open_r[sdram_ba];
  assign any_open_s  = |open_r;
  // Bank bits above the RAM size alias onto the same words.
  assign full_addr_s = {sdram_ba, open_row_r[sdram_ba], sdram_addr[COL_W-1:0]};
  assign mem_addr_s  = full_addr_s[MEM_AW-1:0];
  assign mem_we_s    = is_wr_s && bank_open_s;
  assign mem_rd_s    = is_rd_s && bank_open_s;

  // A write or burst terminate kills any read data still in flight, including this cycle's.
  assign flush_s  = is_wr_s || is_bt_s;
  assign out_v_s  = !flush_s && ((cl_r == 3'd2) ? pv0_r : pv1_r);
  assign out_d_s  = (cl_r == 3'd2) ? mem_rdata_s : pd1_r;
  assign err_code = err_r;

  sdram_emu_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk_clk),
    .we    (mem_we_s),
    .rd    (mem_rd_s),
    .be    (~sdram_dqm),
    .addr  (mem_addr_s),
    .wdata (sdram_dq_in),
    .rdata (mem_rdata_s)
  );

  // Classify the protocol error, if any, carried by this cycle's command.
  always_comb begin
    new_err_s = ERR_NONE;
    if (sdram_cke) begin
      case (cmd_s)
        CMD_ACTIVE: begin
          if (bank_open_s)     new_err_s = ERR_ACT_OPEN;
          else if (!init_done) new_err_s = ERR_NOT_INIT;
          else                 new_err_s = ERR_NONE;
        end
        CMD_READ, CMD_WRITE: begin
          if (!bank_open_s)                     new_err_s = ERR_CLOSED;
          else if (trcd_r[sdram_ba] != 4'd0)    new_err_s = ERR_TRCD;
          else if (!init_done)                  new_err_s = ERR_NOT_INIT;
          else                                  new_err_s = ERR_NONE;
        end
        CMD_REFRESH: begin
          if (any_open_s) new_err_s = ERR_REF_OPEN;
          else            new_err_s = ERR_NONE;
        end
        CMD_LOAD_MODE: begin
          if (any_open_s)                    new_err_s = ERR_MODE_OPEN;
          else if (!mode_valid(sdram_addr))  new_err_s = ERR_MODE_BAD;
          else                               new_err_s = ERR_NONE;
        end
        default: new_err_s = ERR_NONE;
      endcase
    end else begin
      new_err_s = ERR_NONE;
    end
  end

  // Bank table, mode register, refresh/init tracking and the first-error latch.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      open_r     <= 4'b0000;
      cl_r       <= 3'd3;
      ref_cnt_r  <= 4'd0;
      init_done  <= 1'b0;
      err_r      <= ERR_NONE;
      err_sticky <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        open_row_r[i] <= 12'd0;
        trcd_r[i]     <= 4'd0;
      end
    end else if (sdram_cke) begin
      for (int i = 0; i < 4; i++) begin
        if (is_act_s && !bank_open_s && (sdram_ba == 2'(i))) begin
          open_row_r[i] <= sdram_addr;
          open_r[i]     <= 1'b1;
          trcd_r[i]     <= TRCD_LOAD;
        end else begin
          if (trcd_r[i] != 4'd0) trcd_r[i] <= trcd_r[i] - 4'd1;
          if ((is_pre_s && (sdram_addr[A10_BIT] || (sdram_ba == 2'(i)))) ||
              ((is_rd_s || is_wr_s) && sdram_addr[A10_BIT] && (sdram_ba == 2'(i))))
            open_r[i] <= 1'b0;
        end
      end
      if (is_ref_s && !any_open_s && (ref_cnt_r != REF_TARGET)) ref_cnt_r <= ref_cnt_r + 4'd1;
      if (is_mode_s && !any_open_s && mode_valid(sdram_addr)) begin
        cl_r <= sdram_addr[MODE_CL_LSB +: 3];
        if (ref_cnt_r == REF_TARGET) init_done <= 1'b1;
      end
      if ((new_err_s != ERR_NONE) && (err_r == ERR_NONE)) begin
        err_r      <= new_err_s;
        err_sticky <= 1'b1;
      end
    end
  end

  // Read pipeline: flags track in-flight reads, DQM is delayed one edge to meet the data.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pv0_r        <= 1'b0;
      pv1_r        <= 1'b0;
      pd1_r        <= 16'h0000;
      dqm_d_r      <= 2'b00;
      sdram_dq_out <= 16'h0000;
      sdram_dq_oe  <= 2'b00;
    end else if (sdram_cke) begin
      pv0_r        <= mem_rd_s;
      pv1_r        <= !flush_s && pv0_r && (cl_r == 3'd3);
      pd1_r        <= mem_rdata_s;
      dqm_d_r      <= sdram_dqm;
      sdram_dq_out <= out_v_s ? out_d_s : 16'h0000;
      sdram_dq_oe  <= out_v_s ? ~dqm_d_r : 2'b00;
    end
  end

endmodule

// File: tb/tb_sdram_device_emu.sv
// Directed plus randomized bench for sdram_device_emu against a cycle-level
// behavioural model of the SDRAM command rules.
module tb_sdram_device_emu;
  import sdram_emu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic [1:0]  ba;
  logic        cs_n, ras_n, cas_n, we_n, cke;
  logic [1:0]  dqm;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic [1:0]  dq_oe;
  logic        init_done, err_sticky;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  sdram_device_emu dut (
    .clk_clk(clk), .reset_reset(reset), .sdram_addr(addr), .sdram_ba(ba),
    .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_cke(cke), .sdram_dqm(dqm), .sdram_dq_in(dq_in), .sdram_dq_out(dq_out),
    .sdram_dq_oe(dq_oe), .init_done(init_done), .err_sticky(err_sticky), .err_code(err_code)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state
  typedef struct {int due; logic [15:0] data; logic [1:0] wm;} rd_t;
  rd_t         pend[$];
  logic [15:0] mm [4096];
  logic [1:0]  mw [4096];
  logic [1:0]  dqm_hist [int];
  bit          m_open [4];
  int          m_row [4];
  int          m_act [4];
  int          edge_n = 0;
  int          m_cl, m_ref, m_err;
  bit          m_init;
  logic [1:0]  exp_oe = 2'b00;
  logic [1:0]  exp_wm = 2'b00;
  logic [15:0] exp_dq = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int cmd, e, idx, col;
    rd_t p;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_open[i] = 0;
      m_cl = 3; m_ref = 0; m_init = 0; m_err = 0;
      pend.delete();
      exp_oe = 2'b00; exp_dq = 16'h0; exp_wm = 2'b00;
      return;
    end
    if (!cke) return;
    edge_n++;
    dqm_hist[edge_n] = dqm;
    cmd = cs_n ? 7 : int'({ras_n, cas_n, we_n});
    e = 0;
    col = int'(addr) % 256;
    case (cmd)
      3: if (m_open[ba]) e = 4;
         else begin
           if (!m_init) e = 1;
           m_open[ba] = 1; m_row[ba] = int'(addr); m_act[ba] = edge_n;
         end
      4, 5: begin
        if (cmd == 4) pend.delete();
        if (!m_open[ba]) e = 2;
        else begin
          if (edge_n - m_act[ba] < 3) e = 3;
          else if (!m_init) e = 1;
          idx = (int'(ba) * (1 << 20) + m_row[ba] * 256 + col) % 4096;
          if (cmd == 4) begin
            if (!dqm[0]) begin mm[idx][7:0]  = dq_in[7:0];  mw[idx][0] = 1'b1; end
            if (!dqm[1]) begin mm[idx][15:8] = dq_in[15:8]; mw[idx][1] = 1'b1; end
          end else begin
            p.due = edge_n + m_cl - 1; p.data = mm[idx]; p.wm = mw[idx];
            pend.push_back(p);
          end
          if (addr[10]) m_open[ba] = 0;
        end
      end
      2: for (int i = 0; i < 4; i++) if (addr[10] || int'(ba) == i) m_open[i] = 0;
      1: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) e = 5;
         else if (m_ref < 2) m_ref++;
      0: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) e = 6;
         else if (!(((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && addr[2:0] == 3'd0)) e = 7;
         else begin
           m_cl = int'(addr[6:4]);
           if (m_ref == 2) m_init = 1;
         end
      6: pend.delete();
      default: e = 0;
    endcase
    if (e != 0 && m_err == 0) m_err = e;
    exp_oe = 2'b00; exp_dq = 16'h0; exp_wm = 2'b00;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      p = pend.pop_front();
      exp_oe = ~dqm_hist[edge_n - 1];
      exp_dq = p.data;
      exp_wm = p.wm;
    end
  endtask

  task automatic cyc();
    logic [1:0]  lanes;
    logic [15:0] m16;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("dq_oe", dq_oe, exp_oe);
    chk("err_code", err_code, m_err);
    chk("err_sticky", err_sticky, (m_err != 0));
    chk("init_done", init_done, m_init);
    lanes = exp_oe & exp_wm;
    m16 = {{8{lanes[1]}}, {8{lanes[0]}}};
    if (lanes != 2'b00) chk("dq_out", dq_out & m16, exp_dq & m16);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                     input logic [1:0] m, input logic [15:0] d);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; addr = a; dqm = m; dq_in = d; cke = 1'b1;
    cyc();
  endtask

  task automatic nop(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) cmd(CMD_NOP, 2'd0, 12'h000, m, 16'h0000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop(1, 2'b00);
    reset = 1'b0;
  endtask

  task automatic do_init(input logic [11:0] mode);
    cmd(CMD_REFRESH, 2'd0, 12'h000, 2'b00, 16'h0);
    cmd(CMD_REFRESH, 2'd0, 12'h000, 2'b00, 16'h0);
    cmd(CMD_LOAD_MODE, 2'd0, mode, 2'b00, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mw[i] = 2'b00;
    reset = 1'b1; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; cke = 1'b1;
    addr = 12'h0; ba = 2'd0; dqm = 2'b00; dq_in = 16'h0;
    do_reset();
    do_reset();
    chk("rst_dq_oe", dq_oe, 2'b00);
    chk("rst_dq_out", dq_out, 16'h0000);
    chk("rst_init", init_done, 1'b0);
    chk("rst_err", err_code, 3'd0);

    do_init(12'h030);
    chk("init_done_after_load", init_done, 1'b1);

    // Write then read at CL=3
    cmd(CMD_ACTIVE, 2'd1, 12'h005, 2'b00, 16'h0);
    nop(3, 2'b00);
    cmd(CMD_WRITE, 2'd1, 12'h010, 2'b00, 16'hA55A);
    cmd(CMD_READ,  2'd1, 12'h010, 2'b00, 16'h0);
    nop(1, 2'b00);
    chk("cl3_early_oe", dq_oe, 2'b00);
    nop(1, 2'b00);
    chk("cl3_oe", dq_oe, 2'b11);
    chk("cl3_data", dq_out, 16'hA55A);

    // Masked write merges, then a DQM-masked read lane
    cmd(CMD_WRITE, 2'd1, 12'h010, 2'b10, 16'hFFFF);
    cmd(CMD_READ,  2'd1, 12'h010, 2'b00, 16'h0);
    nop(2, 2'b00);
    chk("merge_data", dq_out, 16'hA5FF);
    cmd(CMD_READ,  2'd1, 12'h010, 2'b00, 16'h0);
    nop(1, 2'b01);
    nop(1, 2'b00);
    chk("dqm_oe", dq_oe, 2'b10);
    chk("dqm_hi", dq_out[15:8], 8'hA5);

    // CL=2
    cmd(CMD_PRECHARGE, 2'd0, 12'h400, 2'b00, 16'h0);
    cmd(CMD_LOAD_MODE, 2'd0, 12'h020, 2'b00, 16'h0);
    cmd(CMD_ACTIVE, 2'd1, 12'h005, 2'b00, 16'h0);
    nop(3, 2'b00);
    cmd(CMD_READ,  2'd1, 12'h010, 2'b00, 16'h0);
    chk("cl2_early_oe", dq_oe, 2'b00);
    nop(1, 2'b00);
    chk("cl2_oe", dq_oe, 2'b11);
    chk("cl2_data", dq_out, 16'hA5FF);

    cmd(CMD_PRECHARGE, 2'd0, 12'h400, 2'b00, 16'h0);
    cmd(CMD_LOAD_MODE, 2'd0, 12'h050, 2'b00, 16'h0);
    chk("mode_bad", err_code, 3'd7);

    // Closed bank, then a later TRCD error must not overwrite the code
    do_reset();
    do_init(12'h030);
    cmd(CMD_READ, 2'd2, 12'h000, 2'b00, 16'h0);
    chk("closed", err_code, 3'd2);
    nop(4, 2'b00);
    chk("closed_no_oe", dq_oe, 2'b00);
    cmd(CMD_ACTIVE, 2'd0, 12'h001, 2'b00, 16'h0);
    cmd(CMD_READ, 2'd0, 12'h001, 2'b00, 16'h0);
    chk("trcd_keeps_first", err_code, 3'd2);
    nop(5, 2'b00);

    // Write interrupts read
    cmd(CMD_READ,  2'd0, 12'h001, 2'b00, 16'h0);
    cmd(CMD_WRITE, 2'd0, 12'h001, 2'b00, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      nop(1, 2'b00);
      chk("wr_interrupt_oe", dq_oe, 2'b00);
    end

    // Reset in the middle of a read
    cmd(CMD_READ, 2'd0, 12'h001, 2'b00, 16'h0);
    do_reset();
    chk("midrd_oe", dq_oe, 2'b00);
    chk("midrd_dq", dq_out, 16'h0000);
    chk("midrd_init", init_done, 1'b0);
    chk("midrd_sticky", err_sticky, 1'b0);
    nop(3, 2'b00);

    // Randomized traffic against the model
    do_reset();
    do_init(($urandom_range(1) == 0) ? 12'h020 : 12'h030);
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(99);
      cs_n = 1'b0; ba = 2'($urandom_range(3)); dqm = 2'($urandom_range(3));
      dq_in = 16'($urandom); cke = ($urandom_range(9) != 0);
      if (r < 22) begin
        {ras_n, cas_n, we_n} = CMD_ACTIVE; addr = 12'($urandom_range(3));
      end else if (r < 75) begin
        {ras_n, cas_n, we_n} = (r < 50) ? CMD_READ : CMD_WRITE;
        addr = 12'($urandom_range(7)) | (($urandom_range(4) == 0) ? 12'h400 : 12'h000);
      end else if (r < 85) begin
        {ras_n, cas_n, we_n} = CMD_PRECHARGE; addr = ($urandom_range(1) == 0) ? 12'h400 : 12'h000;
      end else if (r < 89) begin
        {ras_n, cas_n, we_n} = CMD_BURST_TERM; addr = 12'h000;
      end else begin
        {ras_n, cas_n, we_n} = CMD_NOP; addr = 12'h000;
      end
      cyc();
    end
    nop(4, 2'b00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
